keypad_scanner: RTL and testbench

- Scans the calculator's 5x4 key matrix, debounces key presses, and decodes each accepted press into the single-cycle key-event strobes that the calculator control FSM consumes.
- Also supplies the digit value and operator code that travel with those strobes.
- Sits between the board keypad pins and the control/datapath, and is the only source of key events in the design.

---
 rtl/keypad_scanner.sv | 186 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 5x4 key matrix, debounces presses/releases and emits one-cycle key strobes.
// Optional BKSP auto-repeat is built only when KEY_REPEAT_EN is defined.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 5000000
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [4:0] row_n,
    output logic       key_dig,
    output logic       key_op,
    output logic       key_sub,
    output logic       key_ex,
    output logic       key_bksp,
    output logic       key_ms,
    output logic       key_mr,
    output logic       key_mc,
    output logic       key_clr,
    output logic [3:0] digit,
    output logic [1:0] op_code
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {SCAN, DEBOUNCE, EMIT, WAIT_REL, REL_DEBOUNCE} state_t;

    state_t        state;
    logic [3:0]    col_m, col_s;
    logic [2:0]    row, row_next;
    logic [1:0]    col, low_col;
    logic [DW-1:0] div;
    logic [BW-1:0] cnt;
    logic          held;
    logic [3:0]    dig_val;

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep;
`endif

    assign row_n    = ~(5'd1 << row);
    assign row_next = (row == 3'd4) ? 3'd0 : row + 3'd1;
    assign low_col  = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
    assign held     = !col_s[col];
    assign dig_val  = {1'b0, row} * 4'd3 + {2'b0, col} + 4'd1;

    // two-flop synchroniser for the asynchronous column inputs (idle = all high)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
        end else begin
            col_m <= col_n;
            col_s <= col_m;
        end
    end

    // scan/debounce/emit FSM with registered strobes, digit and operator
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= SCAN;
            row      <= 3'd0;
            col      <= 2'd0;
            div      <= '0;
            cnt      <= '0;
            key_dig  <= 1'b0;
            key_op   <= 1'b0;
            key_sub  <= 1'b0;
            key_ex   <= 1'b0;
            key_bksp <= 1'b0;
            key_ms   <= 1'b0;
            key_mr   <= 1'b0;
            key_mc   <= 1'b0;
            key_clr  <= 1'b0;
            digit    <= 4'd0;
            op_code  <= 2'b00;
`ifdef KEY_REPEAT_EN
            rep      <= '0;
`endif
        end else begin
            key_dig  <= 1'b0;
            key_op   <= 1'b0;
            key_sub  <= 1'b0;
            key_ex   <= 1'b0;
            key_bksp <= 1'b0;
            key_ms   <= 1'b0;
            key_mr   <= 1'b0;
            key_mc   <= 1'b0;
            key_clr  <= 1'b0;
            case (state)
                SCAN: begin
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (col_s != 4'hF) begin
                            col   <= low_col;
                            cnt   <= '0;
                            state <= DEBOUNCE;
                        end else begin
                            row <= row_next;
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!held) begin
                        state <= SCAN;
                        row   <= row_next;
                        div   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= EMIT;
                        if (row < 3'd3) begin
                            if (col == 2'd3) begin
                                key_op  <= 1'b1;
                                key_sub <= (row == 3'd1);
                                op_code <= row[1:0];
                            end else begin
                                key_dig <= 1'b1;
                                digit   <= dig_val;
                            end
                        end else if (row == 3'd3) begin
                            key_clr  <= (col == 2'd0);
                            key_ex   <= (col == 2'd2);
                            key_bksp <= (col == 2'd3);
                            if (col == 2'd1) begin
                                key_dig <= 1'b1;
                                digit   <= 4'd0;
                            end
                        end else begin
                            key_ms <= (col == 2'd0);
                            key_mr <= (col == 2'd1);
                            key_mc <= (col == 2'd2);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EMIT: begin
                    state <= WAIT_REL;
`ifdef KEY_REPEAT_EN
                    rep   <= RW'(1);
`endif
                end
                WAIT_REL: begin
                    if (!held) begin
                        state <= REL_DEBOUNCE;
                        cnt   <= '0;
`ifdef KEY_REPEAT_EN
                        rep   <= '0;
`endif
                    end
`ifdef KEY_REPEAT_EN
                    else if (row == 3'd3 && col == 2'd3) begin
                        if (rep == REP_LAST) begin
                            key_bksp <= 1'b1;
                            rep      <= '0;
                        end else begin
                            rep <= rep + 1'b1;
                        end
                    end
`endif
                end
                REL_DEBOUNCE: begin
                    if (held) begin
                        state <= WAIT_REL;
                    end else if (cnt == DB_LAST) begin
                        state <= SCAN;
                        row   <= row_next;
                        div   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, key decode, reset and BKSP repeat.
module tb_keypad_scanner;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_n;
    logic [4:0] row_n;
    logic       key_dig, key_op, key_sub, key_ex, key_bksp, key_ms, key_mr, key_mc, key_clr;
    logic [3:0] digit;
    logic [1:0] op_code;
    logic [19:0] keys = '0;

    int checks = 0;
    int errors = 0;
    int pc [9] = '{default: 0};
    int viol = 0;

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_CYCLES(8)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT_CYCLES(32)
`endif
    ) dut (
        .clock(clock), .reset(reset), .col_n(col_n), .row_n(row_n),
        .key_dig(key_dig), .key_op(key_op), .key_sub(key_sub), .key_ex(key_ex),
        .key_bksp(key_bksp), .key_ms(key_ms), .key_mr(key_mr), .key_mc(key_mc),
        .key_clr(key_clr), .digit(digit), .op_code(op_code)
    );

    always #5 clock = ~clock;

    // key matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 5; r++)
            if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
    end

    // pulse counters and exclusivity monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (key_dig)  pc[0]++;
        if (key_op)   pc[1]++;
        if (key_sub)  pc[2]++;
        if (key_ex)   pc[3]++;
        if (key_bksp) pc[4]++;
        if (key_ms)   pc[5]++;
        if (key_mr)   pc[6]++;
        if (key_mc)   pc[7]++;
        if (key_clr)  pc[8]++;
        if ($countones({key_dig, key_op, key_ex, key_bksp, key_ms, key_mr, key_mc, key_clr}) > 1 || (key_sub && !key_op))
            viol++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_row3_start();
        for (int i = 0; i < 40 && row_n == 5'b10111; i++) @(negedge clock);
        for (int i = 0; i < 40 && row_n != 5'b10111; i++) @(negedge clock);
    endtask

    task automatic test_reset();
        logic [8:0] p;
        reset = 1'b1;
        keys = '0;
        tick(3);
        p = {key_dig, key_op, key_sub, key_ex, key_bksp, key_ms, key_mr, key_mc, key_clr};
        checks++; if (row_n !== 5'b11110) begin errors++; $display("FAIL reset_row: got %b want 11110", row_n); end
        checks++; if (p !== 9'h000) begin errors++; $display("FAIL reset_pulses: got %h want 000", p); end
        checks++; if (digit !== 4'd0) begin errors++; $display("FAIL reset_digit: got %0d want 0", digit); end
        checks++; if (op_code !== 2'b00) begin errors++; $display("FAIL reset_op: got %b want 00", op_code); end
        @(posedge clock); #1 reset = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock); @(negedge clock);
            if (n == 3) begin checks++; if (row_n !== 5'b11110) begin errors++; $display("FAIL scan_dwell: got %b want 11110", row_n); end end
            if (n == 4) begin checks++; if (row_n !== 5'b11101) begin errors++; $display("FAIL scan_row1: got %b want 11101", row_n); end end
            if (n == 16) begin checks++; if (row_n !== 5'b01111) begin errors++; $display("FAIL scan_row4: got %b want 01111", row_n); end end
            if (n == 20) begin checks++; if (row_n !== 5'b11110) begin errors++; $display("FAIL scan_wrap: got %b want 11110", row_n); end end
        end
    endtask

    task automatic test_latency();
        int got = -1;
        reset = 1'b1;
        keys = 20'h00001;
        tick(3);
        @(posedge clock); #1 reset = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clock); @(negedge clock);
            if (key_dig) begin got = n; break; end
        end
        checks++; if (got != 12) begin errors++; $display("FAIL latency: got %0d want 12", got); end
        checks++; if (digit !== 4'd1) begin errors++; $display("FAIL latency_digit: got %0d want 1", digit); end
        keys = '0;
        tick(30);
    endtask

    task automatic test_digit5();
        int s [9];
        int n_chg = -1;
        int others = 0;
        s = pc;
        keys = 20'h1 << 5;
        tick(40);
        checks++; if (row_n !== 5'b11101) begin errors++; $display("FAIL d5_row_held: got %b want 11101", row_n); end
        keys = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            if (row_n !== 5'b11101) begin n_chg = n; break; end
        end
        checks++; if (n_chg != 11) begin errors++; $display("FAIL d5_rel_time: got %0d want 11", n_chg); end
        checks++; if (row_n !== 5'b11011) begin errors++; $display("FAIL d5_next_row: got %b want 11011", row_n); end
        for (int i = 1; i < 9; i++) others += pc[i] - s[i];
        checks++; if (pc[0] - s[0] != 1) begin errors++; $display("FAIL d5_pulses: got %0d want 1", pc[0] - s[0]); end
        checks++; if (others != 0) begin errors++; $display("FAIL d5_other: got %0d want 0", others); end
        checks++; if (digit !== 4'd5) begin errors++; $display("FAIL d5_digit: got %0d want 5", digit); end
        tick(20);
    endtask

    task automatic test_minus();
        int s [9];
        int opc = 0;
        int both = 0;
        s = pc;
        keys = 20'h1 << 7;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (key_op) opc++;
            if (key_op && key_sub) both++;
        end
        keys = '0;
        tick(30);
        checks++; if (opc != 1) begin errors++; $display("FAIL minus_op: got %0d want 1", opc); end
        checks++; if (both != 1) begin errors++; $display("FAIL minus_same_cycle: got %0d want 1", both); end
        checks++; if (pc[0] - s[0] + pc[3] - s[3] + pc[8] - s[8] != 0) begin errors++; $display("FAIL minus_other: got %0d want 0", pc[0] - s[0] + pc[3] - s[3] + pc[8] - s[8]); end
        checks++; if (op_code !== 2'b01) begin errors++; $display("FAIL minus_opcode: got %b want 01", op_code); end
    endtask

    task automatic test_keymap();
        logic [8:0] km_mask [20];
        int km_dig [20];
        int km_op [20];
        int s [9];
        logic [8:0] got;
        int tot;
        int exp_d = 5;
        int exp_op = 1;
        km_mask = '{9'h001, 9'h001, 9'h001, 9'h002, 9'h001, 9'h001, 9'h001, 9'h006, 9'h001, 9'h001,
                    9'h001, 9'h002, 9'h100, 9'h001, 9'h008, 9'h010, 9'h020, 9'h040, 9'h080, 9'h000};
        km_dig  = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, -1, 0, -1, -1, -1, -1, -1, -1};
        km_op   = '{-1, -1, -1, 0, -1, -1, -1, 1, -1, -1, -1, 2, -1, -1, -1, -1, -1, -1, -1, -1};
        for (int k = 0; k < 20; k++) begin
            s = pc;
            keys = 20'h1 << k;
            tick(36);
            keys = '0;
            tick(30);
            tot = 0;
            for (int i = 0; i < 9; i++) begin
                got[i] = (pc[i] != s[i]);
                tot += pc[i] - s[i];
            end
            if (km_dig[k] >= 0) exp_d = km_dig[k];
            if (km_op[k] >= 0) exp_op = km_op[k];
            checks++; if (got !== km_mask[k] || tot != $countones(km_mask[k])) begin errors++; $display("FAIL keymap_%0d: got mask %h count %0d want mask %h", k, got, tot, km_mask[k]); end
            checks++; if (digit !== 4'(exp_d)) begin errors++; $display("FAIL keymap_digit_%0d: got %0d want %0d", k, digit, exp_d); end
            checks++; if (op_code !== 2'(exp_op)) begin errors++; $display("FAIL keymap_op_%0d: got %0d want %0d", k, op_code, exp_op); end
        end
    endtask

    task automatic test_bounce();
        int s [9];
        int tot = 0;
        s = pc;
        wait_row3_start();
        keys = 20'h1 << 12;
        tick(5);
        keys = '0;
        tick(1);
        keys = 20'h1 << 12;
        tick(3);
        keys = '0;
        checks++; if (row_n !== 5'b01111) begin errors++; $display("FAIL bounce_row4: got %b want 01111", row_n); end
        tick(30);
        for (int i = 0; i < 9; i++) tot += pc[i] - s[i];
        checks++; if (pc[8] - s[8] != 0) begin errors++; $display("FAIL bounce_clr: got %0d want 0", pc[8] - s[8]); end
        checks++; if (tot != 0) begin errors++; $display("FAIL bounce_any: got %0d want 0", tot); end
    endtask

    task automatic test_two_keys();
        int s [9];
        s = pc;
        keys = 20'h1;
        tick(36);
        checks++; if (pc[0] - s[0] != 1 || digit !== 4'd1) begin errors++; $display("FAIL two_first: got %0d pulses digit %0d want 1 pulse digit 1", pc[0] - s[0], digit); end
        keys = keys | (20'h1 << 10);
        tick(40);
        checks++; if (pc[0] - s[0] != 1 || digit !== 4'd1) begin errors++; $display("FAIL two_ignored: got %0d pulses digit %0d want 1 pulse digit 1", pc[0] - s[0], digit); end
        keys = 20'h1 << 10;
        tick(40);
        checks++; if (pc[0] - s[0] != 2 || digit !== 4'd9) begin errors++; $display("FAIL two_second: got %0d pulses digit %0d want 2 pulses digit 9", pc[0] - s[0], digit); end
        keys = '0;
        tick(30);
        s = pc;
        keys = (20'h1 << 4) | (20'h1 << 6);
        tick(36);
        keys = '0;
        tick(30);
        checks++; if (pc[0] - s[0] != 1 || digit !== 4'd4) begin errors++; $display("FAIL same_row: got %0d pulses digit %0d want 1 pulse digit 4", pc[0] - s[0], digit); end
    endtask

    task automatic test_reset_mid();
        int s [9];
        int tot = 0;
        logic [8:0] p;
        s = pc;
        wait_row3_start();
        keys = 20'h1 << 14;
        tick(6);
        checks++; if (row_n !== 5'b10111) begin errors++; $display("FAIL rmid_row_held: got %b want 10111", row_n); end
        reset = 1'b1;
        #1;
        p = {key_dig, key_op, key_sub, key_ex, key_bksp, key_ms, key_mr, key_mc, key_clr};
        checks++; if (row_n !== 5'b11110) begin errors++; $display("FAIL rmid_row: got %b want 11110", row_n); end
        checks++; if (digit !== 4'd0 || op_code !== 2'b00) begin errors++; $display("FAIL rmid_regs: got digit %0d op %b want 0 00", digit, op_code); end
        checks++; if (p !== 9'h000) begin errors++; $display("FAIL rmid_pulses: got %h want 000", p); end
        keys = '0;
        tick(3);
        @(posedge clock); #1 reset = 1'b0;
        tick(30);
        for (int i = 0; i < 9; i++) tot += pc[i] - s[i];
        checks++; if (pc[3] - s[3] != 0 || tot != 0) begin errors++; $display("FAIL rmid_no_ex: got ex %0d total %0d want 0 0", pc[3] - s[3], tot); end
    endtask

    task automatic test_repeat();
        int found = 0;
        int reps = 0;
        int exp_reps;
`ifdef KEY_REPEAT_EN
        exp_reps = 3;
`else
        exp_reps = 0;
`endif
        keys = 20'h1 << 15;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (key_bksp) begin found = 1; break; end
        end
        checks++; if (found != 1) begin errors++; $display("FAIL repeat_first: got %0d want 1", found); end
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            if (key_bksp) begin
                reps++;
                checks++; if (n != 32 * reps) begin errors++; $display("FAIL repeat_spacing: got %0d want %0d", n, 32 * reps); end
            end
        end
        checks++; if (reps != exp_reps) begin errors++; $display("FAIL repeat_count: got %0d want %0d", reps, exp_reps); end
        keys = '0;
        tick(30);
    endtask

    task automatic test_exclusive();
        checks++; if (viol != 0) begin errors++; $display("FAIL exclusivity: got %0d want 0", viol); end
    endtask

    // test sequence
    initial begin
        test_reset();
        test_latency();
        test_digit5();
        test_minus();
        test_keymap();
        test_bounce();
        test_two_keys();
        test_reset_mid();
        test_repeat();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
